free_list: RTL
==============

# free_list

Physical-register free list for the R10K-style rename stage. A circular FIFO of free physical register indices, with one index per superscalar lane.
- Supplies `NUM_SUPER` new tags per dispatch group to the map table and ROB.
- Reclaims `Told` tags from the ROB at retire.
- Restores its head pointer from a per-ROB-entry snapshot on branch rollback, so it stays consistent with the map table's backup stack.

## Interface
Parameters (shared `define macros):
- `NUM_SUPER`, 2, dispatch/retire width.
- `NUM_PR`, 64, physical registers; `NUM_PR-32` must be a power of two.
- `NUM_ROB`, 8, ROB entries, which is also the number of snapshot slots.
- `NUM_FL`, `NUM_PR-32`, free-list depth.

Ports (one clock; reset is synchronous and active-high):
- `clock` in 1 — system clock.
- `reset` in 1 — synchronous, active-high.
- `en` in 1 — global stall; when low, all state holds.
- `dispatch_en` in 1 — allocate `NUM_SUPER` tags this cycle.
- `rollback_en` in 1 — restore head from snapshot.
- `ROB_rollback_idx` in `$clog2(NUM_ROB)` — snapshot slot to restore.
- `ROB_idx` in `[NUM_SUPER][$clog2(NUM_ROB)]` — ROB slots of the dispatching group.
- `ROB_FL_out` in `ROB_FL_OUT_t` — `retire_en[NUM_SUPER]` and `Told_idx[NUM_SUPER][$clog2(NUM_PR)]`.
- `FL_Map_Table_out` out `FL_MAP_TABLE_OUT_t` — `T_idx[NUM_SUPER]`, the new tags.
- `FL_ROB_out` out `FL_ROB_OUT_t` — `T_idx[NUM_SUPER]`, identical to the map-table copy.
- `FL_valid` out 1 — at least `NUM_SUPER` free entries exist; dispatch-hazard input.

## Operation
- Storage:
  - `free_list[NUM_FL]` of PR indices.
  - `head`, `tail`, each `$clog2(NUM_FL)+1` bits; the MSB is the wrap bit.
  - `backup_head[NUM_ROB]`.
- Count and hazard: count = `tail - head`, computed modulo `2*NUM_FL`. `FL_valid` = count ≥ `NUM_SUPER`.
- Outputs: `T_idx[i] = free_list[(head+i) mod NUM_FL]`. Outputs are combinational from current state, with no same-cycle bypass of retiring tags.
- Dispatch (`dispatch_en && FL_valid && !rollback_en`):
  - `head += NUM_SUPER`.
  - `backup_head[ROB_idx[j]] = head + NUM_SUPER` for every lane j. This is the post-group state, matching the map-table backup.
- `dispatch_en` while `!FL_valid` is ignored (no state change) and flagged by an assertion.
- Retire: lanes with `retire_en[i]` set are compacted in lane order. Each enabled lane writes `Told_idx[i]` to `free_list[tail + k]`, where k is its rank among enabled lanes. Then `tail += popcount(retire_en)`.
- Rollback: `head = backup_head[ROB_rollback_idx]`. This takes priority over dispatch in the same cycle; that dispatch is dropped.
- Rollback + retire in the same cycle: both apply. Retiring instructions are older than the rollback point.
- Dispatch + retire in the same cycle: both apply, and count changes by `popcount - NUM_SUPER`.
- Invariant: tags of squashed instructions are never retired, so tail never overtakes `backup_head + NUM_FL`. Squashed entries between the restored head and the old head remain intact.
- Retire that would make count > `NUM_FL` is an assertion failure.

## Timing
- Reset state:
  - `free_list[i] = 32+i`, `head = 0`, `tail = NUM_FL` (wrap bit set, i.e. full).
  - `backup_head[*] = 0`.
  - Outputs after reset: `T_idx[i] = 32+i`, `FL_valid = 1`.
- Reset overrides `en`, dispatch, retire and rollback in any cycle, including mid-rollback.
- All updates occur at `posedge clock` with `` `SD `` delay, and only when `en` is high.
- Allocation latency 0: tags are valid in the same cycle `dispatch_en` is sampled. The next group's tags appear the following cycle.
- Reclaim latency 1: a tag retired in cycle N is allocatable from cycle N+1 at the earliest. It is visible on `T_idx` only once it reaches the head.
- Rollback latency 1: the restored tags appear on `T_idx` in the cycle after `rollback_en`.
- Pointer wrap: the index is the low bits; the MSB toggles at wrap. head == tail with differing MSB means full; with equal MSB, empty.

## Structure
- Shared package (sys_defs): `NUM_FL`, `FL_MAP_TABLE_OUT_t`, `FL_ROB_OUT_t`, `ROB_FL_OUT_t`, `FL_RESET`.
- Single module with no sub-module. Retire-lane compaction is a small local `always_comb` loop.
- `DEBUG`-only port `free_list_out`, plus head/tail.

## Test plan
- Reset, then sample → `T_idx = {32,33}`, `FL_valid = 1`, count = 32.
- 16 dispatch groups with no retire → `head = 32` (wrapped, MSB set), `FL_valid = 0`. A 17th `dispatch_en` → no state change, assertion fires.
- From empty, retire `Told` = {5,9} with both lanes, and in the next cycle retire {12} with only lane 1 → `T_idx = {5,9}`, then next group `T_idx[0] = 12`, count 3.
- Dispatch groups A (ROB 0,1) and B (ROB 2,3) from reset, then rollback to ROB 1 → head = 2, `T_idx = {34,35}` again.
- Rollback to ROB 1 with simultaneous `dispatch_en` and a single retire → head = 2, dispatch dropped, tail += 1.
- Run 100 random dispatch/retire cycles with full wrap, using a ROB model → no tag is ever duplicated in flight, and count never leaves [0,32].

Source files
------------

// File: rtl/free_list_pkg.sv
// Shared sizing, bus structs and reset contents for the rename-stage free list.
package free_list_pkg;

    localparam int NUM_SUPER = 2;
    localparam int NUM_PR    = 64;
    localparam int NUM_ROB   = 8;
    localparam int NUM_FL    = NUM_PR - 32;

    localparam int PR_W  = $clog2(NUM_PR);
    localparam int ROB_W = $clog2(NUM_ROB);
    localparam int FL_W  = $clog2(NUM_FL);
    localparam int PTR_W = FL_W + 1;

    typedef logic [PR_W-1:0]  pr_idx_t;
    typedef logic [ROB_W-1:0] rob_idx_t;
    typedef logic [PTR_W-1:0] fl_ptr_t;

    typedef struct packed {
        logic [NUM_SUPER-1:0]    retire_en;
        pr_idx_t [NUM_SUPER-1:0] Told_idx;
    } ROB_FL_OUT_t;

    typedef struct packed {
        pr_idx_t [NUM_SUPER-1:0] T_idx;
    } FL_MAP_TABLE_OUT_t;

    typedef struct packed {
        pr_idx_t [NUM_SUPER-1:0] T_idx;
    } FL_ROB_OUT_t;

    // Architectural registers own tags 0..31, so the free pool starts at 32.
    function automatic pr_idx_t FL_RESET(input int unsigned i);
        return pr_idx_t'(32 + i);
    endfunction

endpackage

// File: rtl/free_list_if.sv
// Rename-stage bundle between dispatch/ROB control and the free list.
interface free_list_if;
    import free_list_pkg::*;

    logic              en;
    logic              dispatch_en;
    logic              rollback_en;
    rob_idx_t          ROB_rollback_idx;
    rob_idx_t [NUM_SUPER-1:0] ROB_idx;
    ROB_FL_OUT_t       ROB_FL_out;
    FL_MAP_TABLE_OUT_t FL_Map_Table_out;
    FL_ROB_OUT_t       FL_ROB_out;
    logic              FL_valid;
    fl_ptr_t           head;
    fl_ptr_t           tail;

    modport master (
        output en, dispatch_en, rollback_en, ROB_rollback_idx, ROB_idx, ROB_FL_out,
        input  FL_Map_Table_out, FL_ROB_out, FL_valid, head, tail
    );

    modport slave (
        input  en, dispatch_en, rollback_en, ROB_rollback_idx, ROB_idx, ROB_FL_out,
        output FL_Map_Table_out, FL_ROB_out, FL_valid, head, tail
    );

endinterface

// File: rtl/free_list.sv
// Circular free list of physical register tags with per-ROB-entry head snapshots
// for branch rollback; head/tail carry a wrap bit to tell full from empty.
module free_list
    import free_list_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    free_list_if.slave fl
);

    pr_idx_t fl_q [NUM_FL];
    pr_idx_t fl_d [NUM_FL];
    fl_ptr_t bk_q [NUM_ROB];
    fl_ptr_t bk_d [NUM_ROB];
    fl_ptr_t head_q, head_d;
    fl_ptr_t tail_q, tail_d;
    fl_ptr_t count, count_d, n_ret;
    logic    fl_valid, dispatch_ok;
    logic [FL_W-1:0] wr_idx, rd_idx;
    pr_idx_t [NUM_SUPER-1:0] out_tags;

    always_comb begin
        count    = tail_q - head_q;
        fl_valid = (count >= fl_ptr_t'(NUM_SUPER));
        rd_idx   = '0;
        out_tags = '0;
        for (int i = 0; i < NUM_SUPER; i++) begin
            rd_idx      = head_q[FL_W-1:0] + FL_W'(i);
            out_tags[i] = fl_q[rd_idx];
        end
    end

    // Retiring lanes are packed densely behind tail in lane order.
    always_comb begin
        fl_d   = fl_q;
        n_ret  = '0;
        wr_idx = '0;
        for (int i = 0; i < NUM_SUPER; i++) begin
            if (fl.ROB_FL_out.retire_en[i]) begin
                wr_idx       = tail_q[FL_W-1:0] + n_ret[FL_W-1:0];
                fl_d[wr_idx] = fl.ROB_FL_out.Told_idx[i];
                n_ret        = n_ret + fl_ptr_t'(1);
            end
        end
        tail_d = tail_q + n_ret;
    end

    // Snapshots hold the post-group head so they line up with the map-table backups.
    always_comb begin
        dispatch_ok = fl.dispatch_en && fl_valid && !fl.rollback_en;
        head_d      = head_q;
        bk_d        = bk_q;
        if (fl.rollback_en) begin
            head_d = bk_q[fl.ROB_rollback_idx];
        end else if (dispatch_ok) begin
            head_d = head_q + fl_ptr_t'(NUM_SUPER);
            for (int j = 0; j < NUM_SUPER; j++) begin
                bk_d[fl.ROB_idx[j]] = head_q + fl_ptr_t'(NUM_SUPER);
            end
        end
        count_d = tail_d - head_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= fl_ptr_t'(NUM_FL);
            for (int i = 0; i < NUM_FL; i++) begin
                fl_q[i] <= FL_RESET(i);
            end
            for (int r = 0; r < NUM_ROB; r++) begin
                bk_q[r] <= '0;
            end
        end else if (fl.en) begin
            head_q <= head_d;
            tail_q <= tail_d;
            fl_q   <= fl_d;
            bk_q   <= bk_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && fl.en) begin
            assert (!(fl.dispatch_en && !fl_valid && !fl.rollback_en))
                else $warning("free_list: dispatch_en with FL_valid low, group dropped");
            assert (count_d <= fl_ptr_t'(NUM_FL))
                else $warning("free_list: retire overflows the free list");
        end
    end

    assign fl.FL_valid               = fl_valid;
    assign fl.FL_Map_Table_out.T_idx = out_tags;
    assign fl.FL_ROB_out.T_idx       = out_tags;
    assign fl.head                   = head_q;
    assign fl.tail                   = tail_q;

endmodule
